// File: rtl/bank_pkg.sv
// Shared definitions for the bank SRAM controller.
//   - Opcode values carried on iq_sc_opcode_i[1:0]
//   - Bit positions inside the 2-bit per-offset cacheline state
//   - Controller FSM state encoding
package bank_pkg;

    localparam logic [1:0] OP_WRITE    = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_LINEFILL = 2'd2;
    localparam logic [1:0] OP_EVICT    = 2'd3;

    localparam int ST_VALID = 0;
    localparam int ST_DIRTY = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_WB,
        WR_SR,
        RD_SR,
        RD_RSP,
        LF_RD,
        LF_W0,
        LF_W1,
        EV_RD,
        EV_CAP,
        EV_SEND
    } sc_state_e;

endpackage

// File: rtl/bank_sram_evict_seq.sv
// Evict sequencer: walks the dirty offsets of one line (offset 0 first) and
// holds the captured beat for the BIU write path until it is accepted.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i, dirty_i  load the dirty-offset mask when an evict is accepted
//   line_i            line index of the evict in progress
//   cap_i, rdata_i    capture the SRAM read data into the beat register
//   send_i            controller is presenting the beat
//   wready_i          BIU accepts the beat
//   cur_off_o         offset currently being transferred
//   more_o            another dirty offset remains after the current one
//   wvalid_o, waddr_o, wdata_o  BIU beat (zero when not valid)
module bank_sram_evict_seq
    import bank_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            dirty_i,
    input  logic [5:0]            line_i,
    input  logic                  cap_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  send_i,
    input  logic                  wready_i,
    output logic                  cur_off_o,
    output logic                  more_o,
    output logic                  wvalid_o,
    output logic [6:0]            waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o
);

    logic [1:0]            pend_q, pend_d;
    logic [DATA_WIDTH-1:0] beat_q, beat_d;

    // Lowest pending offset is served first.
    assign cur_off_o = ~pend_q[0];
    assign more_o    = &pend_q;

    always_comb begin
        pend_d = pend_q;
        beat_d = beat_q;
        if (start_i) begin
            pend_d = dirty_i;
        end
        if (cap_i) begin
            beat_d = rdata_i;
        end
        if (send_i && wready_i) begin
            pend_d[cur_off_o] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        beat_q <= beat_d;
    end

    // Beat register and offset only change on capture/handshake, so the
    // presented address and data stay stable while the BIU stalls.
    assign wvalid_o = send_i;
    assign waddr_o  = send_i ? {line_i, cur_off_o} : 7'd0;
    assign wdata_o  = send_i ? beat_q : '0;

endmodule

// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: executes one issued op at a time (write, read,
// read-with-linefill, evict) against the single-port data SRAM.
// Ports:
//   iq_sc_*     issued op from the bank issue queue (valid/ready)
//   sram_*      single-port data SRAM, read data arrives one cycle later
//   sc_wbuf_*   write-buffer read port, data one cycle later
//   sc_lfb_*    linefill-buffer read port, both offsets one cycle later
//   sc_ch_*     one-cycle channel response (read data or write ack)
//   sc_biu_*    dirty evict beats to the BIU write path (valid/ready)
module bank_sram_ctrl
    import bank_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int WBUF_ID_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     iq_sc_valid_i,
    output logic                     iq_sc_ready_o,
    input  logic [1:0]               iq_sc_channel_id_i,
    input  logic [2:0]               iq_sc_opcode_i,
    input  logic [6:0]               iq_sc_set_way_offset_i,
    input  logic [WBUF_ID_WIDTH-1:0] iq_sc_wbuffer_id_i,
    input  logic [2:0]               iq_sc_xbar_rob_num_i,
    input  logic [1:0]               iq_sc_cacheline_state_offset0_i,
    input  logic [1:0]               iq_sc_cacheline_state_offset1_i,
    output logic                     sram_en_o,
    output logic                     sram_wen_o,
    output logic [6:0]               sram_addr_o,
    output logic [DATA_WIDTH-1:0]    sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]    sram_rdata_i,
    output logic                     sc_wbuf_ren_o,
    output logic [WBUF_ID_WIDTH-1:0] sc_wbuf_id_o,
    input  logic [DATA_WIDTH-1:0]    wbuf_sc_rdata_i,
    output logic                     sc_lfb_ren_o,
    output logic [5:0]               sc_lfb_idx_o,
    input  logic [2*DATA_WIDTH-1:0]  lfb_sc_rdata_i,
    output logic                     sc_ch_valid_o,
    output logic [1:0]               sc_ch_id_o,
    output logic [2:0]               sc_ch_rob_id_o,
    output logic                     sc_ch_is_write_o,
    output logic [DATA_WIDTH-1:0]    sc_ch_data_o,
    output logic                     sc_biu_wvalid_o,
    input  logic                     sc_biu_wready_i,
    output logic [6:0]               sc_biu_waddr_o,
    output logic [DATA_WIDTH-1:0]    sc_biu_wdata_o
);

    sc_state_e                state_q, state_d;
    logic [6:0]               swo_q, swo_d;
    logic [1:0]               ch_q, ch_d;
    logic [2:0]               rob_q, rob_d;
    logic [WBUF_ID_WIDTH-1:0] wbid_q, wbid_d;
    logic [2*DATA_WIDTH-1:0]  lf_q, lf_d;

    logic       accept;
    logic [1:0] op;
    logic [1:0] ev_dirty;
    logic       ev_start, ev_cap, ev_send, ev_cur_off, ev_more;

    // Opcode bit2 is reserved and the valid bits are not needed here.
    logic unused_bits;
    assign unused_bits = ^{iq_sc_opcode_i[2],
                           iq_sc_cacheline_state_offset0_i[ST_VALID],
                           iq_sc_cacheline_state_offset1_i[ST_VALID]};

    assign op       = iq_sc_opcode_i[1:0];
    assign accept   = iq_sc_valid_i && (state_q == IDLE);
    assign ev_dirty = {iq_sc_cacheline_state_offset1_i[ST_DIRTY],
                       iq_sc_cacheline_state_offset0_i[ST_DIRTY]};
    assign ev_start = accept && (op == OP_EVICT);

    always_comb begin
        state_d          = state_q;
        swo_d            = swo_q;
        ch_d             = ch_q;
        rob_d            = rob_q;
        wbid_d           = wbid_q;
        lf_d             = lf_q;
        iq_sc_ready_o    = (state_q == IDLE);
        sram_en_o        = 1'b0;
        sram_wen_o       = 1'b0;
        sram_addr_o      = 7'd0;
        sram_wdata_o     = '0;
        sc_wbuf_ren_o    = 1'b0;
        sc_wbuf_id_o     = '0;
        sc_lfb_ren_o     = 1'b0;
        sc_lfb_idx_o     = 6'd0;
        sc_ch_valid_o    = 1'b0;
        sc_ch_id_o       = 2'd0;
        sc_ch_rob_id_o   = 3'd0;
        sc_ch_is_write_o = 1'b0;
        sc_ch_data_o     = '0;
        ev_cap           = 1'b0;
        ev_send          = 1'b0;

        case (state_q)
            IDLE: begin
                if (iq_sc_valid_i) begin
                    swo_d  = iq_sc_set_way_offset_i;
                    ch_d   = iq_sc_channel_id_i;
                    rob_d  = iq_sc_xbar_rob_num_i;
                    wbid_d = iq_sc_wbuffer_id_i;
                    case (op)
                        OP_WRITE:    state_d = WR_WB;
                        OP_READ:     state_d = RD_SR;
                        OP_LINEFILL: state_d = LF_RD;
                        // A fully clean evict has nothing to move.
                        OP_EVICT:    state_d = (|ev_dirty) ? EV_RD : IDLE;
                        default:     state_d = IDLE;
                    endcase
                end
            end
            WR_WB: begin
                sc_wbuf_ren_o = 1'b1;
                sc_wbuf_id_o  = wbid_q;
                state_d       = WR_SR;
            end
            WR_SR: begin
                sram_en_o        = 1'b1;
                sram_wen_o       = 1'b1;
                sram_addr_o      = swo_q;
                sram_wdata_o     = wbuf_sc_rdata_i;
                sc_ch_valid_o    = 1'b1;
                sc_ch_id_o       = ch_q;
                sc_ch_rob_id_o   = rob_q;
                sc_ch_is_write_o = 1'b1;
                state_d          = IDLE;
            end
            RD_SR: begin
                sram_en_o   = 1'b1;
                sram_addr_o = swo_q;
                state_d     = RD_RSP;
            end
            RD_RSP: begin
                sc_ch_valid_o  = 1'b1;
                sc_ch_id_o     = ch_q;
                sc_ch_rob_id_o = rob_q;
                sc_ch_data_o   = sram_rdata_i;
                state_d        = IDLE;
            end
            LF_RD: begin
                sc_lfb_ren_o = 1'b1;
                sc_lfb_idx_o = swo_q[6:1];
                state_d      = LF_W0;
            end
            LF_W0: begin
                // Linefill data is only valid this cycle; keep offset1 for later.
                lf_d         = lfb_sc_rdata_i;
                sram_en_o    = 1'b1;
                sram_wen_o   = 1'b1;
                sram_addr_o  = {swo_q[6:1], 1'b0};
                sram_wdata_o = lfb_sc_rdata_i[DATA_WIDTH-1:0];
                state_d      = LF_W1;
            end
            LF_W1: begin
                sram_en_o      = 1'b1;
                sram_wen_o     = 1'b1;
                sram_addr_o    = {swo_q[6:1], 1'b1};
                sram_wdata_o   = lf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                sc_ch_valid_o  = 1'b1;
                sc_ch_id_o     = ch_q;
                sc_ch_rob_id_o = rob_q;
                sc_ch_data_o   = swo_q[0] ? lf_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : lf_q[DATA_WIDTH-1:0];
                state_d        = IDLE;
            end
            EV_RD: begin
                sram_en_o   = 1'b1;
                sram_addr_o = {swo_q[6:1], ev_cur_off};
                state_d     = EV_CAP;
            end
            EV_CAP: begin
                ev_cap  = 1'b1;
                state_d = EV_SEND;
            end
            EV_SEND: begin
                ev_send = 1'b1;
                if (sc_biu_wready_i) begin
                    state_d = ev_more ? EV_RD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        swo_q  <= swo_d;
        ch_q   <= ch_d;
        rob_q  <= rob_d;
        wbid_q <= wbid_d;
        lf_q   <= lf_d;
    end

    bank_sram_evict_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_evict_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (ev_start),
        .dirty_i   (ev_dirty),
        .line_i    (swo_q[6:1]),
        .cap_i     (ev_cap),
        .rdata_i   (sram_rdata_i),
        .send_i    (ev_send),
        .wready_i  (sc_biu_wready_i),
        .cur_off_o (ev_cur_off),
        .more_o    (ev_more),
        .wvalid_o  (sc_biu_wvalid_o),
        .waddr_o   (sc_biu_waddr_o),
        .wdata_o   (sc_biu_wdata_o)
    );

endmodule

// File: tb/tb_bank_sram_ctrl.sv
module tb_bank_sram_ctrl;

    localparam int DW = 128;
    localparam int WW = 8;

    logic          clk;
    logic          rst;
    logic          iq_valid;
    logic          iq_ready;
    logic [1:0]    iq_ch;
    logic [2:0]    iq_op;
    logic [6:0]    iq_swo;
    logic [WW-1:0] iq_wid;
    logic [2:0]    iq_rob;
    logic [1:0]    iq_st0, iq_st1;
    logic          sram_en, sram_wen;
    logic [6:0]    sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          wbuf_ren;
    logic [WW-1:0] wbuf_id;
    logic [DW-1:0] wbuf_rdata;
    logic          lfb_ren;
    logic [5:0]    lfb_idx;
    logic [2*DW-1:0] lfb_rdata;
    logic          ch_valid;
    logic [1:0]    ch_id;
    logic [2:0]    ch_rob;
    logic          ch_isw;
    logic [DW-1:0] ch_data;
    logic          biu_wvalid, biu_wready;
    logic [6:0]    biu_waddr;
    logic [DW-1:0] biu_wdata;

    bank_sram_ctrl #(.DATA_WIDTH(DW), .WBUF_ID_WIDTH(WW)) dut (
        .clk_i                           (clk),
        .rst_i                           (rst),
        .iq_sc_valid_i                   (iq_valid),
        .iq_sc_ready_o                   (iq_ready),
        .iq_sc_channel_id_i              (iq_ch),
        .iq_sc_opcode_i                  (iq_op),
        .iq_sc_set_way_offset_i          (iq_swo),
        .iq_sc_wbuffer_id_i              (iq_wid),
        .iq_sc_xbar_rob_num_i            (iq_rob),
        .iq_sc_cacheline_state_offset0_i (iq_st0),
        .iq_sc_cacheline_state_offset1_i (iq_st1),
        .sram_en_o                       (sram_en),
        .sram_wen_o                      (sram_wen),
        .sram_addr_o                     (sram_addr),
        .sram_wdata_o                    (sram_wdata),
        .sram_rdata_i                    (sram_rdata),
        .sc_wbuf_ren_o                   (wbuf_ren),
        .sc_wbuf_id_o                    (wbuf_id),
        .wbuf_sc_rdata_i                 (wbuf_rdata),
        .sc_lfb_ren_o                    (lfb_ren),
        .sc_lfb_idx_o                    (lfb_idx),
        .lfb_sc_rdata_i                  (lfb_rdata),
        .sc_ch_valid_o                   (ch_valid),
        .sc_ch_id_o                      (ch_id),
        .sc_ch_rob_id_o                  (ch_rob),
        .sc_ch_is_write_o                (ch_isw),
        .sc_ch_data_o                    (ch_data),
        .sc_biu_wvalid_o                 (biu_wvalid),
        .sc_biu_wready_i                 (biu_wready),
        .sc_biu_waddr_o                  (biu_waddr),
        .sc_biu_wdata_o                  (biu_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected value of every DUT output for one cycle.
    typedef struct packed {
        logic          rdy;
        logic          en;
        logic          wen;
        logic [6:0]    addr;
        logic [DW-1:0] wd;
        logic          wbren;
        logic [WW-1:0] wbid;
        logic          lfren;
        logic [5:0]    lfidx;
        logic          chv;
        logic [1:0]    chid;
        logic [2:0]    rob;
        logic          isw;
        logic [DW-1:0] chd;
        logic          bv;
        logic [6:0]    ba;
        logic [DW-1:0] bd;
    } exp_t;

    typedef struct packed {
        int         c;
        logic [4:0] f;
        logic [DW-1:0] v;
    } lit_t;

    localparam int NF = 17;
    localparam int F_RDY = 0, F_EN = 1, F_WEN = 2, F_ADDR = 3, F_WD = 4, F_WBREN = 5,
                   F_WBID = 6, F_LFREN = 7, F_LFIDX = 8, F_CHV = 9, F_CHID = 10,
                   F_ROB = 11, F_ISW = 12, F_CHD = 13, F_BV = 14, F_BA = 15, F_BD = 16;

    exp_t exp_a [int];
    bit   wr_sched [int];
    lit_t lits [$];

    logic [DW-1:0]   ref_mem  [128];
    logic [DW-1:0]   stub_mem [128];
    logic [DW-1:0]   wbuf_mem [256];
    logic [2*DW-1:0] lfb_mem  [64];

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    function automatic logic [DW-1:0] fld(input exp_t s, input int f);
        case (f)
            F_RDY:   return DW'(s.rdy);
            F_EN:    return DW'(s.en);
            F_WEN:   return DW'(s.wen);
            F_ADDR:  return DW'(s.addr);
            F_WD:    return s.wd;
            F_WBREN: return DW'(s.wbren);
            F_WBID:  return DW'(s.wbid);
            F_LFREN: return DW'(s.lfren);
            F_LFIDX: return DW'(s.lfidx);
            F_CHV:   return DW'(s.chv);
            F_CHID:  return DW'(s.chid);
            F_ROB:   return DW'(s.rob);
            F_ISW:   return DW'(s.isw);
            F_CHD:   return s.chd;
            F_BV:    return DW'(s.bv);
            F_BA:    return DW'(s.ba);
            default: return s.bd;
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_RDY:   return "iq_ready";
            F_EN:    return "sram_en";
            F_WEN:   return "sram_wen";
            F_ADDR:  return "sram_addr";
            F_WD:    return "sram_wdata";
            F_WBREN: return "wbuf_ren";
            F_WBID:  return "wbuf_id";
            F_LFREN: return "lfb_ren";
            F_LFIDX: return "lfb_idx";
            F_CHV:   return "ch_valid";
            F_CHID:  return "ch_id";
            F_ROB:   return "ch_rob";
            F_ISW:   return "ch_is_write";
            F_CHD:   return "ch_data";
            F_BV:    return "biu_wvalid";
            F_BA:    return "biu_waddr";
            default: return "biu_wdata";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
        end
    endtask

    // Environment stubs: SRAM, write buffer and linefill buffer respond one
    // cycle after a read; garbage otherwise so mistimed sampling shows up.
    always @(posedge clk) begin
        if (rst) begin
            stub_mem <= ref_mem;
        end else if (sram_en && sram_wen) begin
            stub_mem[sram_addr] <= sram_wdata;
        end
        sram_rdata <= (sram_en && !sram_wen) ? stub_mem[sram_addr] : rand128();
        wbuf_rdata <= wbuf_ren ? wbuf_mem[wbuf_id] : rand128();
        lfb_rdata  <= lfb_ren ? lfb_mem[lfb_idx] : {rand128(), rand128()};
    end

    initial begin
        biu_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_sched.exists(cyc)) biu_wready = wr_sched[cyc];
            else                      biu_wready = 1'($urandom_range(0, 1));
        end
    end

    // Single compare process: model expectation plus literal pins.
    exp_t cmp_e, cmp_a;
    always @(negedge clk) begin
        cmp_e = exp_a.exists(cyc) ? exp_a[cyc] : idle_e();
        if (exp_a.exists(cyc)) exp_a.delete(cyc);
        cmp_a.rdy   = iq_ready;
        cmp_a.en    = sram_en;
        cmp_a.wen   = sram_wen;
        cmp_a.addr  = sram_addr;
        cmp_a.wd    = sram_wdata;
        cmp_a.wbren = wbuf_ren;
        cmp_a.wbid  = wbuf_id;
        cmp_a.lfren = lfb_ren;
        cmp_a.lfidx = lfb_idx;
        cmp_a.chv   = ch_valid;
        cmp_a.chid  = ch_id;
        cmp_a.rob   = ch_rob;
        cmp_a.isw   = ch_isw;
        cmp_a.chd   = ch_data;
        cmp_a.bv    = biu_wvalid;
        cmp_a.ba    = biu_waddr;
        cmp_a.bd    = biu_wdata;
        for (int f = 0; f < NF; f++) begin
            chk(fname(f), fld(cmp_a, f), fld(cmp_e, f));
        end
        for (int i = lits.size() - 1; i >= 0; i--) begin
            if (lits[i].c == cyc) begin
                chk({"lit_", fname(int'(lits[i].f))}, fld(cmp_a, int'(lits[i].f)), lits[i].v);
                lits.delete(i);
            end
        end
    end

    task automatic lit(input int c, input int f, input logic [DW-1:0] v);
        lit_t l;
        l.c = c;
        l.f = 5'(f);
        l.v = v;
        lits.push_back(l);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one op (DUT idle) and record the full expected output trace.
    // t is the first cycle after acceptance; the DUT is idle again at t+len.
    task automatic issue(input logic [1:0] op, input logic [6:0] swo, input logic [1:0] ch,
                         input logic [2:0] rob, input logic [WW-1:0] wid,
                         input logic [1:0] st0, input logic [1:0] st1,
                         input int stall0, input int stall1, output int t, output int len);
        exp_t e;
        int k, st;
        logic [5:0] line;
        logic [1:0] dirty;
        logic [6:0] a;
        line     = swo[6:1];
        iq_valid = 1'b1;
        iq_op    = {1'b0, op};
        iq_swo   = swo;
        iq_ch    = ch;
        iq_rob   = rob;
        iq_wid   = wid;
        iq_st0   = st0;
        iq_st1   = st1;
        t = cyc + 1;
        len = 0;
        case (op)
            2'd0: begin
                e = '0; e.wbren = 1'b1; e.wbid = wid;
                exp_a[t] = e;
                e = '0; e.en = 1'b1; e.wen = 1'b1; e.addr = swo; e.wd = wbuf_mem[wid];
                e.chv = 1'b1; e.chid = ch; e.rob = rob; e.isw = 1'b1;
                exp_a[t+1] = e;
                ref_mem[swo] = wbuf_mem[wid];
                len = 2;
            end
            2'd1: begin
                e = '0; e.en = 1'b1; e.addr = swo;
                exp_a[t] = e;
                e = '0; e.chv = 1'b1; e.chid = ch; e.rob = rob; e.chd = ref_mem[swo];
                exp_a[t+1] = e;
                len = 2;
            end
            2'd2: begin
                e = '0; e.lfren = 1'b1; e.lfidx = line;
                exp_a[t] = e;
                e = '0; e.en = 1'b1; e.wen = 1'b1; e.addr = {line, 1'b0};
                e.wd = lfb_mem[line][DW-1:0];
                exp_a[t+1] = e;
                e = '0; e.en = 1'b1; e.wen = 1'b1; e.addr = {line, 1'b1};
                e.wd = lfb_mem[line][2*DW-1:DW];
                e.chv = 1'b1; e.chid = ch; e.rob = rob;
                e.chd = swo[0] ? lfb_mem[line][2*DW-1:DW] : lfb_mem[line][DW-1:0];
                exp_a[t+2] = e;
                ref_mem[{line, 1'b0}] = lfb_mem[line][DW-1:0];
                ref_mem[{line, 1'b1}] = lfb_mem[line][2*DW-1:DW];
                len = 3;
            end
            default: begin
                dirty = {st1[1], st0[1]};
                k = t;
                for (int o = 0; o < 2; o++) begin
                    if (dirty[o]) begin
                        a = {line, o[0]};
                        e = '0; e.en = 1'b1; e.addr = a;
                        exp_a[k] = e;
                        exp_a[k+1] = '0;
                        st = (o == 0) ? stall0 : stall1;
                        for (int s = 0; s <= st; s++) begin
                            e = '0; e.bv = 1'b1; e.ba = a; e.bd = ref_mem[a];
                            exp_a[k+2+s] = e;
                            wr_sched[k+2+s] = (s == st);
                        end
                        k = k + 3 + st;
                    end
                end
                len = k - t;
            end
        endcase
        @(posedge clk);
        #1;
        iq_valid = 1'b0;
        iq_op    = 3'($urandom);
        iq_swo   = 7'($urandom);
        iq_st0   = 2'($urandom);
        iq_st1   = 2'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, len, gap;
        rst      = 1'b1;
        iq_valid = 1'b0;
        iq_op    = 3'd0;
        iq_swo   = 7'd0;
        iq_ch    = 2'd0;
        iq_rob   = 3'd0;
        iq_wid   = '0;
        iq_st0   = 2'd0;
        iq_st1   = 2'd0;
        for (int i = 0; i < 128; i++) ref_mem[i] = rand128();
        for (int i = 0; i < 256; i++) wbuf_mem[i] = rand128();
        for (int i = 0; i < 64; i++)  lfb_mem[i] = {rand128(), rand128()};
        wbuf_mem[8'h11] = {16{8'hA5}};
        lfb_mem[5]      = {{16{8'hBB}}, {16{8'hAA}}};

        lit(1, F_RDY, 1);
        lit(1, F_EN, 0);
        lit(1, F_CHV, 0);
        lit(1, F_BV, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Write A5.. to 0x25 from wbuf entry 0x11.
        issue(2'd0, 7'h25, 2'd1, 3'd3, 8'h11, 2'b00, 2'b00, 0, 0, t, len);
        lit(t, F_WBREN, 1);
        lit(t, F_WBID, 8'h11);
        lit(t+1, F_WEN, 1);
        lit(t+1, F_ADDR, 7'h25);
        lit(t+1, F_WD, {16{8'hA5}});
        lit(t+1, F_ISW, 1);
        lit(t+1, F_ROB, 3);
        wait_until(t + len);

        // Read it back on channel 2, rob 5.
        issue(2'd1, 7'h25, 2'd2, 3'd5, 8'h00, 2'b00, 2'b00, 0, 0, t, len);
        lit(t, F_EN, 1);
        lit(t, F_RDY, 0);
        lit(t+1, F_RDY, 0);
        lit(t+1, F_CHV, 1);
        lit(t+1, F_CHID, 2);
        lit(t+1, F_ROB, 5);
        lit(t+1, F_CHD, {16{8'hA5}});
        wait_until(t + len);

        // Linefill line 5, response for offset 1.
        issue(2'd2, 7'h0B, 2'd0, 3'd1, 8'h00, 2'b00, 2'b00, 0, 0, t, len);
        lit(t+1, F_ADDR, 7'h0A);
        lit(t+1, F_WD, {16{8'hAA}});
        lit(t+2, F_ADDR, 7'h0B);
        lit(t+2, F_WD, {16{8'hBB}});
        lit(t+2, F_CHD, {16{8'hBB}});
        wait_until(t + len);

        // Evict line 5, both dirty, beat 0 stalled three cycles.
        issue(2'd3, 7'h0A, 2'd0, 3'd0, 8'h00, 2'b10, 2'b10, 3, 0, t, len);
        lit(t+2, F_BA, 7'h0A);
        lit(t+2, F_BD, {16{8'hAA}});
        lit(t+4, F_BA, 7'h0A);
        lit(t+4, F_BD, {16{8'hAA}});
        lit(t+5, F_BV, 1);
        lit(t+8, F_BA, 7'h0B);
        lit(t+8, F_BD, {16{8'hBB}});
        lit(t+8, F_CHV, 0);
        wait_until(t + len);

        // Clean evict: idle again immediately.
        issue(2'd3, 7'h0A, 2'd0, 3'd0, 8'h00, 2'b01, 2'b01, 0, 0, t, len);
        lit(t, F_RDY, 1);
        lit(t, F_EN, 0);
        lit(t, F_BV, 0);
        wait_until(t + len);

        // Reset while a beat is stalled in the send phase.
        issue(2'd3, 7'h0A, 2'd0, 3'd0, 8'h00, 2'b10, 2'b10, 6, 0, t, len);
        wait_until(t + 3);
        rst = 1'b1;
        for (int c = t + 4; c <= t + len + 1; c++) begin
            if (exp_a.exists(c))    exp_a.delete(c);
            if (wr_sched.exists(c)) wr_sched.delete(c);
        end
        lit(t+4, F_BV, 0);
        lit(t+4, F_RDY, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_until(t + 12);

        // Randomized op stream.
        for (int n = 0; n < 300; n++) begin
            issue(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 2'($urandom),
                  3'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), t, len);
            gap = int'($urandom_range(0, 2));
            wait_until(t + len + gap);
        end

        wait_until(cyc + 4);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
